// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and the D-stage register layout used by the fetch/decode boundary.
package y86_pkg;

  typedef enum logic [3:0] {
    I_HALT   = 4'd0,
    I_NOP    = 4'd1,
    I_RRMOVQ = 4'd2,
    I_IRMOVQ = 4'd3,
    I_RMMOVQ = 4'd4,
    I_MRMOVQ = 4'd5,
    I_OPQ    = 4'd6,
    I_JXX    = 4'd7,
    I_CALL   = 4'd8,
    I_RET    = 4'd9,
    I_PUSHQ  = 4'd10,
    I_POPQ   = 4'd11
  } icode_e;

  typedef enum logic [2:0] {
    S_AOK = 3'd1,
    S_HLT = 3'd2,
    S_ADR = 3'd3,
    S_INS = 3'd4
  } stat_e;

  localparam logic [3:0] R_NONE = 4'hF;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
  } d_fields_t;

  localparam d_fields_t D_BUBBLE = '{
    stat:  S_AOK,
    icode: I_NOP,
    ifun:  4'd0,
    rA:    R_NONE,
    rB:    R_NONE,
    valC:  64'd0,
    valP:  64'd0
  };

endpackage

// File: rtl/d_pipe_reg_pipe_ctrl.sv
// Combinational hazard control: load/use, ret processing and branch mispredict.
module pipe_ctrl
  import y86_pkg::*;
(
  input  logic [3:0] D_icode,
  input  logic [3:0] E_icode,
  input  logic [3:0] E_dstM,
  input  logic [3:0] M_icode,
  input  logic [3:0] d_srcA,
  input  logic [3:0] d_srcB,
  input  logic       e_Cnd,
  output logic       F_stall,
  output logic       D_stall,
  output logic       D_bubble,
  output logic       E_bubble
);

  logic load_use;
  logic ret_pend;
  logic mispred;

  assign load_use = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
                    (E_dstM != R_NONE) &&
                    ((E_dstM == d_srcA) || (E_dstM == d_srcB));

  assign ret_pend = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);

  assign mispred  = (E_icode == I_JXX) && !e_Cnd;

  // A load/use stall takes precedence over the ret bubble so D keeps the dependent instruction.
  assign F_stall  = load_use || ret_pend;
  assign D_stall  = load_use;
  assign D_bubble = mispred || (ret_pend && !load_use);
  assign E_bubble = mispred || load_use;

endmodule

// File: rtl/d_pipe_reg.sv
// Fetch-to-decode pipeline register with hazard control.
// Optional D_PERF_CNT_EN adds saturating stall/bubble event counters.
module d_pipe_reg
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  f_stat,
  input  logic [3:0]  f_icode,
  input  logic [3:0]  f_ifun,
  input  logic [3:0]  f_rA,
  input  logic [3:0]  f_rB,
  input  logic [63:0] f_valC,
  input  logic [63:0] f_valP,
  input  logic [3:0]  d_srcA,
  input  logic [3:0]  d_srcB,
  input  logic [3:0]  E_icode,
  input  logic [3:0]  E_dstM,
  input  logic        e_Cnd,
  input  logic [3:0]  M_icode,
  output logic [2:0]  D_stat,
  output logic [3:0]  D_icode,
  output logic [3:0]  D_ifun,
  output logic [3:0]  D_rA,
  output logic [3:0]  D_rB,
  output logic [63:0] D_valC,
  output logic [63:0] D_valP,
  output logic        F_stall,
  output logic        D_stall,
  output logic        D_bubble,
  output logic        E_bubble
`ifdef D_PERF_CNT_EN
  ,
  output logic [31:0] D_stall_cnt,
  output logic [31:0] D_bubble_cnt
`endif
);

  d_fields_t f_in;
  d_fields_t dreg_p1;

  assign f_in = '{
    stat:  f_stat,
    icode: f_icode,
    ifun:  f_ifun,
    rA:    f_rA,
    rB:    f_rB,
    valC:  f_valC,
    valP:  f_valP
  };

  pipe_ctrl u_ctrl (
    .D_icode  (D_icode),
    .E_icode  (E_icode),
    .E_dstM   (E_dstM),
    .M_icode  (M_icode),
    .d_srcA   (d_srcA),
    .d_srcB   (d_srcB),
    .e_Cnd    (e_Cnd),
    .F_stall  (F_stall),
    .D_stall  (D_stall),
    .D_bubble (D_bubble),
    .E_bubble (E_bubble)
  );

  // F -> D stage boundary
  always_ff @(posedge clk) begin
    if (reset)
      dreg_p1 <= D_BUBBLE;
    else if (D_stall)
      dreg_p1 <= dreg_p1;
    else if (D_bubble)
      dreg_p1 <= D_BUBBLE;
    else
      dreg_p1 <= f_in;
  end

  assign D_stat  = dreg_p1.stat;
  assign D_icode = dreg_p1.icode;
  assign D_ifun  = dreg_p1.ifun;
  assign D_rA    = dreg_p1.rA;
  assign D_rB    = dreg_p1.rB;
  assign D_valC  = dreg_p1.valC;
  assign D_valP  = dreg_p1.valP;

`ifdef D_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      D_stall_cnt  <= 32'd0;
      D_bubble_cnt <= 32'd0;
    end else begin
      if (D_stall && (D_stall_cnt != 32'hFFFF_FFFF))
        D_stall_cnt <= D_stall_cnt + 32'd1;
      if (D_bubble && !D_stall && (D_bubble_cnt != 32'hFFFF_FFFF))
        D_bubble_cnt <= D_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule
